// File: rtl/ycc_pkg.sv
// Shared constants, FSM state type and clamp helpers for the YCrCb -> RGB block converter.
package ycc_pkg;

   localparam int ROWS        = 8;
   localparam int PIX_PER_ROW = 8;
   localparam int COEF_FRAC   = 8;
   localparam int ROW_W       = $clog2(ROWS);

   localparam logic signed [19:0] COEF_RCR   = 20'sd359;
   localparam logic signed [19:0] COEF_GCB   = 20'sd88;
   localparam logic signed [19:0] COEF_GCR   = 20'sd183;
   localparam logic signed [19:0] COEF_BCB   = 20'sd454;
   localparam logic signed [8:0]  CHROMA_OFS = 9'sd128;
   localparam logic signed [19:0] ROUND_OFS  = 20'sd128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [7:0] clamp_u8(input logic signed [19:0] v);
      logic [7:0] res;
      if (v < 20'sd0) begin
         res = 8'd0;
      end else if (v > 20'sd255) begin
         res = 8'd255;
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

   function automatic logic is_clip(input logic signed [19:0] v);
      return (v < 20'sd0) || (v > 20'sd255);
   endfunction

endpackage

// File: rtl/ycrcb2rgb_pixel.sv
// Combinational single-pixel YCrCb -> RGB with round-half-up and clamp to 0..255.
// With YCC2RGB_CLIP_CNT_EN defined, also reports which components were clamped.
module ycrcb2rgb_pixel
   import ycc_pkg::*;
(
   input  logic [7:0] i_y,
   input  logic [7:0] i_cr,
   input  logic [7:0] i_cb,
   output logic [7:0] o_r,
   output logic [7:0] o_g,
   output logic [7:0] o_b
`ifdef YCC2RGB_CLIP_CNT_EN
   ,
   output logic [2:0] o_clip
`endif
);

   logic signed [8:0]  w_dr;
   logic signed [8:0]  w_db;
   logic signed [19:0] w_dr_x;
   logic signed [19:0] w_db_x;
   logic signed [19:0] w_ys;
   logic signed [19:0] w_r_sh;
   logic signed [19:0] w_g_sh;
   logic signed [19:0] w_b_sh;

   assign w_dr   = $signed({1'b0, i_cr}) - CHROMA_OFS;
   assign w_db   = $signed({1'b0, i_cb}) - CHROMA_OFS;
   assign w_dr_x = {{11{w_dr[8]}}, w_dr};
   assign w_db_x = {{11{w_db[8]}}, w_db};
   assign w_ys   = $signed({4'd0, i_y, 8'd0});

   // Rounding offset is added before the arithmetic shift so negatives floor correctly.
   assign w_r_sh = (w_ys + COEF_RCR * w_dr_x + ROUND_OFS) >>> COEF_FRAC;
   assign w_g_sh = (w_ys - COEF_GCB * w_db_x - COEF_GCR * w_dr_x + ROUND_OFS) >>> COEF_FRAC;
   assign w_b_sh = (w_ys + COEF_BCB * w_db_x + ROUND_OFS) >>> COEF_FRAC;

   assign o_r = clamp_u8(w_r_sh);
   assign o_g = clamp_u8(w_g_sh);
   assign o_b = clamp_u8(w_b_sh);

`ifdef YCC2RGB_CLIP_CNT_EN
   assign o_clip = {is_clip(w_b_sh), is_clip(w_g_sh), is_clip(w_r_sh)};
`endif

endmodule

// File: rtl/ycrcb2rgb_8in8.sv
// 8x8 block YCrCb -> RGB converter, one 8-pixel row per clock, registered 512-bit outputs.
// Optional clip_count output when YCC2RGB_CLIP_CNT_EN is defined.
module ycrcb2rgb_8in8
   import ycc_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [511:0] Y_8in8,
   input  logic [511:0] Cr_8in8,
   input  logic [511:0] Cb_8in8,
   output logic [511:0] R_8in8,
   output logic [511:0] G_8in8,
   output logic [511:0] B_8in8,
   output logic         busy,
   output logic         data_valid
`ifdef YCC2RGB_CLIP_CNT_EN
   ,
   output logic [7:0]   clip_count
`endif
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ROW_W-1:0]   r_row;
   logic [511:0]       r_y;
   logic [511:0]       r_cr;
   logic [511:0]       r_cb;
   logic [63:0]        w_y_row;
   logic [63:0]        w_cr_row;
   logic [63:0]        w_cb_row;
   logic [63:0]        w_r_row;
   logic [63:0]        w_g_row;
   logic [63:0]        w_b_row;
   logic [8:0]         w_row_base;

   assign w_row_base = {r_row, 6'd0};
   assign w_y_row    = r_y[w_row_base +: 64];
   assign w_cr_row   = r_cr[w_row_base +: 64];
   assign w_cb_row   = r_cb[w_row_base +: 64];

`ifdef YCC2RGB_CLIP_CNT_EN
   logic [PIX_PER_ROW*3-1:0] w_clip;
   logic [4:0]               w_clip_row;
   logic [8:0]               w_clip_sum;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < PIX_PER_ROW; gi++) begin : g_pix
         ycrcb2rgb_pixel u_pix (
            .i_y   (w_y_row[8*gi +: 8]),
            .i_cr  (w_cr_row[8*gi +: 8]),
            .i_cb  (w_cb_row[8*gi +: 8]),
            .o_r   (w_r_row[8*gi +: 8]),
            .o_g   (w_g_row[8*gi +: 8]),
            .o_b   (w_b_row[8*gi +: 8])
`ifdef YCC2RGB_CLIP_CNT_EN
            ,
            .o_clip(w_clip[3*gi +: 3])
`endif
         );
      end
   endgenerate

`ifdef YCC2RGB_CLIP_CNT_EN
   // Number of clamped components in the current row, and saturating block total.
   always_comb begin
      w_clip_row = 5'd0;
      for (int i = 0; i < PIX_PER_ROW*3; i++) begin
         w_clip_row = w_clip_row + {4'd0, w_clip[i]};
      end
      w_clip_sum = {1'b0, clip_count} + {4'd0, w_clip_row};
   end
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = CONV;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CONV: begin
            if (r_row == ROW_W'(ROWS - 1)) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = CONV;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Input latches, row counter, status flags and output row writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_row      <= '0;
         r_y        <= '0;
         r_cr       <= '0;
         r_cb       <= '0;
         R_8in8     <= '0;
         G_8in8     <= '0;
         B_8in8     <= '0;
         busy       <= 1'b0;
         data_valid <= 1'b0;
`ifdef YCC2RGB_CLIP_CNT_EN
         clip_count <= 8'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_y        <= Y_8in8;
                  r_cr       <= Cr_8in8;
                  r_cb       <= Cb_8in8;
                  r_row      <= '0;
                  busy       <= 1'b1;
                  data_valid <= 1'b0;
`ifdef YCC2RGB_CLIP_CNT_EN
                  clip_count <= 8'd0;
`endif
               end
            end
            CONV: begin
               R_8in8[w_row_base +: 64] <= w_r_row;
               G_8in8[w_row_base +: 64] <= w_g_row;
               B_8in8[w_row_base +: 64] <= w_b_row;
               r_row                    <= r_row + 1'b1;
`ifdef YCC2RGB_CLIP_CNT_EN
               clip_count <= (w_clip_sum > 9'd255) ? 8'd255 : w_clip_sum[7:0];
`endif
            end
            DONE: begin
               data_valid <= 1'b1;
               busy       <= 1'b0;
            end
            default: begin
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ycrcb2rgb_8in8.sv
// Scoreboard bench for ycrcb2rgb_8in8; clip_count is checked when YCC2RGB_CLIP_CNT_EN is defined.
module tb_ycrcb2rgb_8in8;

   typedef struct {
      logic [511:0] r;
      logic [511:0] g;
      logic [511:0] b;
      int           clip;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [511:0] y_in, cr_in, cb_in;
   logic [511:0] r_out, g_out, b_out;
   logic         busy, data_valid;
`ifdef YCC2RGB_CLIP_CNT_EN
   logic [7:0]   clip_count;
`endif

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   logic mon_prev = 1'b0;

   always #5 clk = ~clk;

   ycrcb2rgb_8in8 dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .Y_8in8    (y_in),
      .Cr_8in8   (cr_in),
      .Cb_8in8   (cb_in),
      .R_8in8    (r_out),
      .G_8in8    (g_out),
      .B_8in8    (b_out),
      .busy      (busy),
      .data_valid(data_valid)
`ifdef YCC2RGB_CLIP_CNT_EN
      ,
      .clip_count(clip_count)
`endif
   );

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0b exp=%0b", name, got, exp);
      end
   endtask

   task automatic chk512(input string name, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic exp_t uni(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input int clip);
      exp_t e;
      e.r = {64{r}};
      e.g = {64{g}};
      e.b = {64{b}};
      e.clip = clip;
      return e;
   endfunction

   // Reference conversion in plain integer arithmetic.
   function automatic int conv(input int acc, inout int clips);
      int v;
      v = (acc + 128) >>> 8;
      if (v < 0) begin
         clips++;
         return 0;
      end
      if (v > 255) begin
         clips++;
         return 255;
      end
      return v;
   endfunction

   task automatic build_pattern(output logic [511:0] y, output logic [511:0] cr,
                                output logic [511:0] cb, output exp_t e);
      int yy, rr, bb, dr, db, clips;
      clips = 0;
      for (int r = 0; r < 8; r++) begin
         for (int p = 0; p < 8; p++) begin
            yy = 16 + 30*r + 3*p;
            rr = 40 + 20*r + p;
            bb = 200 - 18*r - 2*p;
            y[64*r + 8*p +: 8]  = 8'(yy);
            cr[64*r + 8*p +: 8] = 8'(rr);
            cb[64*r + 8*p +: 8] = 8'(bb);
            dr = rr - 128;
            db = bb - 128;
            e.r[64*r + 8*p +: 8] = 8'(conv(yy*256 + 359*dr, clips));
            e.g[64*r + 8*p +: 8] = 8'(conv(yy*256 - 88*db - 183*dr, clips));
            e.b[64*r + 8*p +: 8] = 8'(conv(yy*256 + 454*db, clips));
         end
      end
      e.clip = clips;
   endtask

   task automatic wait_dv(input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(posedge clk);
         #1;
         if (data_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout got=no_data_valid exp=data_valid", name);
      end
   endtask

   // Issue start at a posedge (edge 0); optionally check busy/data_valid on each later edge.
   task automatic run_block(input string name, input logic [511:0] y, input logic [511:0] cr,
                            input logic [511:0] cb, input bit chk_lat);
      @(negedge clk);
      y_in = y; cr_in = cr; cb_in = cb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk1({name, "_dv_edge0"}, data_valid, 1'b0);
      chk1({name, "_busy_edge0"}, busy, 1'b1);
      if (chk_lat) begin
         for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            chk1($sformatf("%s_busy_e%0d", name, k), busy, (k <= 8));
            chk1($sformatf("%s_dv_e%0d", name, k), data_valid, (k == 9));
         end
      end else begin
         wait_dv(name);
      end
   endtask

   // Monitor: on each rising data_valid pop the scoreboard and compare the block.
   always @(negedge clk) begin
      exp_t e;
      if (data_valid && !mon_prev) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_block got=data_valid exp=none_pending");
         end else begin
            e = sb.pop_front();
            chk512("R_block", r_out, e.r);
            chk512("G_block", g_out, e.g);
            chk512("B_block", b_out, e.b);
`ifdef YCC2RGB_CLIP_CNT_EN
            checks++;
            if (int'(clip_count) != e.clip) begin
               failures++;
               $display("FAIL clip_count got=%0d exp=%0d", clip_count, e.clip);
            end
`endif
         end
      end
      mon_prev = data_valid;
   end

   initial begin
      logic [511:0] py, pcr, pcb;
      exp_t         pe;

      reset = 1'b1;
      start = 1'b0;
      y_in = '0; cr_in = '0; cb_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk512("reset_R", r_out, 512'd0);
      chk512("reset_G", g_out, 512'd0);
      chk512("reset_B", b_out, 512'd0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_dv", data_valid, 1'b0);
      reset = 1'b0;

      // Neutral grey, with full latency/busy profile.
      sb.push_back(uni(8'd128, 8'd128, 8'd128, 0));
      run_block("grey", {64{8'd128}}, {64{8'd128}}, {64{8'd128}}, 1'b1);

      // Strong red: R clamps high.
      sb.push_back(uni(8'd255, 8'd164, 8'd255, 64));
      run_block("red", {64{8'd255}}, {64{8'd255}}, {64{8'd128}}, 1'b0);

      // Per-row pattern, with a start re-pulse at edge 4 carrying different inputs.
      build_pattern(py, pcr, pcb, pe);
      sb.push_back(pe);
      @(negedge clk);
      y_in = py; cr_in = pcr; cb_in = pcb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      y_in = '0; cr_in = '0; cb_in = '0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk1("repulse_busy", busy, 1'b1);
      wait_dv("pattern");

      // Back-to-back start after data_valid: all-zero input, R and B clamp low.
      sb.push_back(uni(8'd0, 8'd136, 8'd0, 128));
      run_block("zero", '0, '0, '0, 1'b1);

      // Reset at edge 5 of a conversion aborts it; nothing is expected from that block.
      @(negedge clk);
      y_in = {64{8'd76}}; cr_in = {64{8'd255}}; cb_in = {64{8'd85}};
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk512("abort_R", r_out, 512'd0);
      chk512("abort_G", g_out, 512'd0);
      chk512("abort_B", b_out, 512'd0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_dv", data_valid, 1'b0);

      // Same inputs after the abort convert normally.
      sb.push_back(uni(8'd254, 8'd0, 8'd0, 0));
      run_block("after_abort", {64{8'd76}}, {64{8'd255}}, {64{8'd85}}, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
